// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
package spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_slv_state_e;

  localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_slave_rx_tx_if.sv
// SPI pad signals plus the register/FIFO client side of the slave endpoint.
interface spi_slave_rx_tx_if #(
  parameter int DATA_W = 8
);
  logic              sclk_i;
  logic              ss_n_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_load_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              tx_underrun_o;
  logic              busy_o;

  modport slave (
    input  sclk_i, ss_n_i, mosi_i, tx_data_i, tx_load_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o
  );

  modport master (
    output sclk_i, ss_n_i, mosi_i, tx_data_i, tx_load_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Everything clears to 0: a select line held low through reset then reads as
  // "already selected", so a frame in flight cannot fake an ss_n fall afterwards.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave: oversampled receive shifter plus a reply shifter fed from a one-word holding register.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  spi_slave_rx_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (bus.sclk_i),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (bus.ss_n_i),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  // Same depth as the sclk path, so the sample lines up with the rise strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_i};
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;  // the final bit goes straight into rx_data
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              word_done_q, word_done_d;
  logic              reload;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= SPI_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      word_done_q  <= word_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    word_done_d  = word_done_q;
    reload       = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        if (ss_fall) begin
          reload      = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          state_d     = SPI_ACTIVE;
        end
      end
      SPI_ACTIVE: begin
        // Deselect beats any coincident sclk edge; a partial word is dropped.
        if (ss_rise) begin
          state_d     = SPI_IDLE;
          word_done_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              rx_data_d   = {rx_shift_q, mosi_s};
              rx_valid_d  = 1'b1;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (word_done_q) begin
              reload      = 1'b1;
              word_done_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    if (reload) begin
      tx_shift_d   = hold_valid_q ? hold_data_q : '0;
      underrun_d   = ~hold_valid_q;
      hold_valid_d = 1'b0;
    end
    // Applied after the reload so a same-cycle load is kept, not consumed.
    if (bus.tx_load_i && !hold_valid_q) begin
      hold_data_d  = bus.tx_data_i;
      hold_valid_d = 1'b1;
    end
  end

  assign bus.miso_oe_o     = (state_q == SPI_ACTIVE);
  assign bus.miso_o        = (state_q == SPI_ACTIVE) & tx_shift_q[DATA_W-1];
  assign bus.busy_o        = (state_q == SPI_ACTIVE);
  assign bus.tx_ready_o    = ~hold_valid_q;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Self-checking bench: table-driven single-word frames, hand-written corner sequences, random bursts vs a word-level model.
module tb_spi_slave_rx_tx;
  import spi_pkg::*;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  spi_slave_rx_tx_if #(.DATA_W(W)) bus ();

  spi_slave_rx_tx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] rx_q[$];
  int unders = 0;
  always @(negedge clk_i) begin
    if (bus.rx_valid_o) rx_q.push_back(bus.rx_data_o);
    if (bus.tx_underrun_o) unders++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Word-level reference: a one-entry holding register that is filled by
  // accepted loads and emptied at every frame start / word boundary.
  bit           m_hv = 1'b0;
  logic [W-1:0] m_hd = '0;

  task automatic model_load(input logic [W-1:0] d);
    if (!m_hv) begin
      m_hv = 1'b1;
      m_hd = d;
    end
  endtask

  task automatic model_take(output logic [W-1:0] d, inout int under);
    d = m_hv ? m_hd : '0;
    if (!m_hv) under++;
    m_hv = 1'b0;
  endtask

  task automatic client_load(input logic [W-1:0] d);
    @(negedge clk_i);
    bus.tx_data_i = d;
    bus.tx_load_i = 1'b1;
    @(negedge clk_i);
    bus.tx_load_i = 1'b0;
    model_load(d);
  endtask

  logic [W-1:0] f_mosi[4];
  bit           f_lden[4];
  logic [W-1:0] f_ldd[4];
  logic [W-1:0] f_miso[4];
  logic [W-1:0] e_miso[4];
  int           e_under;
  int           g_under;

  // The last sclk fall and the ss_n rise are driven together, so no reload
  // happens after the final word of a frame.
  task automatic do_frame(input string tag, input int nw, input int stop_after);
    int bits = 0;
    int u0;
    rx_q.delete();
    u0 = unders;
    e_under = 0;
    model_take(e_miso[0], e_under);
    bus.ss_n_i = 1'b0;
    wait_clks(HALF);
    chk({tag, " busy"}, bus.busy_o, 1);
    chk({tag, " miso_oe"}, bus.miso_oe_o, 1);
    for (int w = 0; w < nw; w++) begin
      f_miso[w] = '0;
      for (int b = W - 1; b >= 0; b--) begin
        bus.mosi_i = f_mosi[w][b];
        wait_clks(HALF);
        bus.sclk_i = 1'b1;
        f_miso[w][b] = bus.miso_o;
        if (b == 4 && f_lden[w]) client_load(f_ldd[w]);
        wait_clks(HALF);
        bits++;
        if (stop_after != 0 && bits == stop_after) begin
          bus.sclk_i = 1'b0;
          wait_clks(HALF);
          bus.ss_n_i = 1'b1;
          wait_clks(2 * HALF);
          g_under = unders - u0;
          return;
        end
        bus.sclk_i = 1'b0;
        if (w == nw - 1 && b == 0) bus.ss_n_i = 1'b1;
      end
      if (w < nw - 1) model_take(e_miso[w + 1], e_under);
    end
    wait_clks(2 * HALF);
    g_under = unders - u0;
    $display("frame %s: words=%0d rx=%0d first_miso=%02h underruns=%0d",
             tag, nw, rx_q.size(), f_miso[0], g_under);
  endtask

  typedef struct {
    bit           pre_en;
    logic [W-1:0] pre;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_miso;
    int           exp_under;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bus.sclk_i = 1'b0; bus.ss_n_i = 1'b1; bus.mosi_i = 1'b0;
    bus.tx_load_i = 1'b0; bus.tx_data_i = '0;
    reset_i = 1'b1;
    wait_clks(4);
    chk("rst miso", bus.miso_o, 0);
    chk("rst miso_oe", bus.miso_oe_o, 0);
    chk("rst tx_ready", bus.tx_ready_o, 1);
    chk("rst rx_data", bus.rx_data_o, 0);
    chk("rst rx_valid", bus.rx_valid_o, 0);
    chk("rst underrun", bus.tx_underrun_o, 0);
    chk("rst busy", bus.busy_o, 0);
    reset_i = 1'b0;
    wait_clks(4);

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'h00, 1};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h81, 0};
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pre_en) client_load(vecs[i].pre);
      f_mosi[0] = vecs[i].mosi;
      f_lden[0] = 1'b0;
      do_frame($sformatf("vec%0d", i), 1, 0);
      chk($sformatf("vec%0d rx_count", i), rx_q.size(), 1);
      if (rx_q.size() > 0) chk($sformatf("vec%0d rx_data", i), rx_q[0], vecs[i].mosi);
      chk($sformatf("vec%0d miso", i), f_miso[0], vecs[i].exp_miso);
      chk($sformatf("vec%0d underrun", i), g_under, vecs[i].exp_under);
      chk($sformatf("vec%0d idle", i), bus.busy_o, 0);
    end

    // Three-word burst with the client refilling mid-word.
    client_load(8'h11);
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
    f_lden[0] = 1'b1;  f_lden[1] = 1'b1;  f_lden[2] = 1'b0;
    f_ldd[0]  = 8'h22; f_ldd[1]  = 8'h33;
    do_frame("burst", 3, 0);
    chk("burst rx_count", rx_q.size(), 3);
    for (int w = 0; w < 3 && w < rx_q.size(); w++) chk($sformatf("burst rx%0d", w), rx_q[w], w + 1);
    chk("burst miso0", f_miso[0], 8'h11);
    chk("burst miso1", f_miso[1], 8'h22);
    chk("burst miso2", f_miso[2], 8'h33);
    chk("burst underrun", g_under, 0);

    // Deselect after 5 bits, then a clean frame.
    client_load(8'h99);
    f_mosi[0] = 8'hC3; f_lden[0] = 1'b0;
    do_frame("abort", 1, 5);
    chk("abort rx_count", rx_q.size(), 0);
    chk("abort idle", bus.busy_o, 0);
    client_load(8'h42);
    f_mosi[0] = 8'hFF;
    do_frame("after_abort", 1, 0);
    chk("after_abort rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("after_abort rx_data", rx_q[0], 8'hFF);
    chk("after_abort miso", f_miso[0], 8'h42);

    // Reset in the middle of a word.
    client_load(8'h66);
    rx_q.delete();
    bus.ss_n_i = 1'b0;
    wait_clks(HALF);
    for (int b = 0; b < 3; b++) begin
      bus.mosi_i = b[0];
      wait_clks(HALF); bus.sclk_i = 1'b1;
      if (b == 1) client_load(8'h24);
      wait_clks(HALF); bus.sclk_i = 1'b0;
    end
    chk("pre_rst tx_ready", bus.tx_ready_o, 0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    m_hv = 1'b0;
    chk("midrst miso", bus.miso_o, 0);
    chk("midrst miso_oe", bus.miso_oe_o, 0);
    chk("midrst tx_ready", bus.tx_ready_o, 1);
    chk("midrst rx_data", bus.rx_data_o, 0);
    chk("midrst busy", bus.busy_o, 0);
    for (int b = 0; b < 5; b++) begin
      bus.mosi_i = 1'b1;
      wait_clks(HALF); bus.sclk_i = 1'b1;
      wait_clks(HALF); bus.sclk_i = 1'b0;
    end
    chk("postrst rx_count", rx_q.size(), 0);
    chk("postrst busy", bus.busy_o, 0);
    bus.ss_n_i = 1'b1;
    wait_clks(2 * HALF);
    f_mosi[0] = 8'hB7; f_lden[0] = 1'b0;
    do_frame("after_rst", 1, 0);
    chk("after_rst rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("after_rst rx_data", rx_q[0], 8'hB7);
    chk("after_rst miso", f_miso[0], 8'h00);
    chk("after_rst underrun", g_under, 1);

    // A load while the holding register is full is ignored.
    client_load(8'h55);
    chk("full tx_ready", bus.tx_ready_o, 0);
    client_load(8'h77);
    f_mosi[0] = 8'h0F;
    do_frame("ignore_load", 1, 0);
    chk("ignore_load miso", f_miso[0], 8'h55);
    chk("ignore_load tx_ready", bus.tx_ready_o, 1);

    // Random bursts against the word-level model.
    for (int t = 0; t < 15; t++) begin
      int nw;
      nw = $urandom_range(1, 3);
      if ($urandom_range(0, 2) != 0) client_load(W'($urandom));
      for (int w = 0; w < 4; w++) begin
        f_mosi[w] = W'($urandom);
        f_lden[w] = ($urandom_range(0, 3) != 0);
        f_ldd[w]  = W'($urandom);
      end
      do_frame($sformatf("rnd%0d", t), nw, 0);
      chk($sformatf("rnd%0d rx_count", t), rx_q.size(), nw);
      for (int w = 0; w < nw; w++) begin
        if (w < rx_q.size()) chk($sformatf("rnd%0d rx%0d", t, w), rx_q[w], f_mosi[w]);
        chk($sformatf("rnd%0d miso%0d", t, w), f_miso[w], e_miso[w]);
      end
      chk($sformatf("rnd%0d underrun", t), g_under, e_under);
      chk($sformatf("rnd%0d tx_ready", t), bus.tx_ready_o, !m_hv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
